// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Builds 8N1 by default; define UART_TX_PARITY_EN for 8E1 (even parity after D7).
module uart_tx_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk_50m,
    input  logic                       rst,
    input  logic                       tx_tick,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_out,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [2:0]        r_bit_cnt;
    logic [IW-1:0]     r_last;
    logic              r_stop_half;
`ifdef UART_TX_PARITY_EN
    logic              r_par;
`endif
    logic [IW-1:0]     w_win;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic              w_hs;
    logic [DATA_W-1:0] w_byte;

    // Search from last+1 so the most recently served requester goes to the back.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = IW'((int'(r_last) + k) % N_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign req_ready = (!rst && r_state == S_IDLE && w_any) ? (N_REQ'(1) << w_win) : '0;
    assign w_hs      = |(req_valid & req_ready);
    assign w_byte    = req_data[w_win*DATA_W +: DATA_W];

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_last      <= IW'(N_REQ - 1);
            r_stop_half <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
            tx_out      <= 1'b1;
            busy        <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_shreg  <= w_byte;
`ifdef UART_TX_PARITY_EN
                        r_par    <= ^w_byte;
`endif
                        grant_id <= w_win;
                        r_last   <= w_win;
                        busy     <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                // A tick coincident with acceptance is skipped so the start bit gets a full period.
                S_START: begin
                    if (tx_tick) begin
                        tx_out    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_out    <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (tx_tick) begin
                        tx_out  <= r_par;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_tick) begin
                        if (r_stop_half) begin
                            busy        <= 1'b0;
                            r_stop_half <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            tx_out      <= 1'b1;
                            r_stop_half <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
